oc28_seq_ctrl: RTL and testbench



---
 rtl/oc28_seq_ctrl_pkg.sv | 17 +
 rtl/oc28_seq_ctrl_if.sv | 25 ++
 rtl/oc28_seq_ctrl_ones_count7.sv | 14 +
 rtl/oc28_seq_ctrl.sv | 110 +++++++++++
 tb/tb_oc28_seq_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/oc28_seq_ctrl_pkg.sv
// Shared constants, FSM state type and the count-width helper for oc28_seq_ctrl.
package oc_pkg;

    localparam int SLICE_W = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } oc_state_e;

    // Bits needed to hold the largest possible ones-count of the operand word.
    function automatic int count_w(input int nslice);
        return $clog2(SLICE_W * nslice + 1);
    endfunction

endpackage

// File: rtl/oc28_seq_ctrl_if.sv
// Request/result bundle for oc28_seq_ctrl; majority exists only with OC_MAJORITY_EN.
// Handshake: start is sampled only while busy=0; done is a one-cycle pulse with count (and majority) valid.
interface oc28_seq_ctrl_if
    import oc_pkg::*;
#(
    parameter int NSLICE = 4
) ();

    logic                           start;
    logic [SLICE_W*NSLICE-1:0]      data_in;
    logic                           busy;
    logic                           done;
    logic [count_w(NSLICE)-1:0]     count;
    oc_state_e                      state;
`ifdef OC_MAJORITY_EN
    logic                           majority;

    modport master (output start, data_in, input busy, done, count, state, majority);
    modport slave  (input start, data_in, output busy, done, count, state, majority);
`else
    modport master (output start, data_in, input busy, done, count, state);
    modport slave  (input start, data_in, output busy, done, count, state);
`endif

endinterface

// File: rtl/oc28_seq_ctrl_ones_count7.sv
// Combinational ones counter for a single 7-bit slice.
module ones_count7 (
    input  logic [6:0] din,
    output logic [2:0] ones
);

    always_comb begin
        ones = '0;
        for (int i = 0; i < 7; i++) begin
            ones = ones + 3'(din[i]);
        end
    end

endmodule

// File: rtl/oc28_seq_ctrl.sv
// Sequential ones counter: one 7-bit slice per cycle through a shared ones_count7.
// Optional feature macro OC_MAJORITY_EN adds a registered majority flag.
module oc28_seq_ctrl
    import oc_pkg::*;
#(
    parameter int NSLICE = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    oc28_seq_ctrl_if.slave  bus
);

    localparam int W     = SLICE_W * NSLICE;
    localparam int CW    = count_w(NSLICE);
    localparam int IDX_W = $clog2(NSLICE);

    oc_state_e          state_q, state_d;
    logic [W-1:0]       shadow_q, shadow_d;
    logic [CW-1:0]      acc_q, acc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CW-1:0]      count_q, count_d;
`ifdef OC_MAJORITY_EN
    logic               majority_q, majority_d;
`endif

    logic [SLICE_W-1:0] slice;
    logic [2:0]         slice_ones;
    logic [CW-1:0]      sum;

    always_comb begin
        slice = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx_q == IDX_W'(i)) slice = shadow_q[i*SLICE_W +: SLICE_W];
        end
    end

    ones_count7 u_ones (
        .din  (slice),
        .ones (slice_ones)
    );

    // Cannot overflow: CW covers the full-word maximum of 7*NSLICE.
    assign sum = acc_q + CW'(slice_ones);

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        count_d  = count_q;
`ifdef OC_MAJORITY_EN
        majority_d = majority_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    shadow_d = bus.data_in;
                    acc_d    = '0;
                    idx_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (idx_q == IDX_W'(NSLICE - 1)) begin
                    count_d = sum;
`ifdef OC_MAJORITY_EN
                    majority_d = (sum > CW'(W / 2));
`endif
                    state_d = DONE;
                end else begin
                    acc_d = sum;
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
            count_q  <= '0;
`ifdef OC_MAJORITY_EN
            majority_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            count_q  <= count_d;
`ifdef OC_MAJORITY_EN
            majority_q <= majority_d;
`endif
        end
    end

    assign bus.busy  = (state_q != IDLE);
    assign bus.done  = (state_q == DONE);
    assign bus.count = count_q;
    assign bus.state = state_q;
`ifdef OC_MAJORITY_EN
    assign bus.majority = majority_q;
`endif

endmodule

// File: tb/tb_oc28_seq_ctrl.sv
// Scoreboard bench for oc28_seq_ctrl: random and directed operands against a popcount model.
module tb_oc28_seq_ctrl;
  import oc_pkg::*;

  localparam int NSLICE = 4;
  localparam int W      = SLICE_W * NSLICE;
  localparam int CW     = count_w(NSLICE);

  logic clk;
  logic rst_n;

  oc28_seq_ctrl_if #(.NSLICE(NSLICE)) bus ();

  oc28_seq_ctrl #(.NSLICE(NSLICE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [CW-1:0] exp_q[$];
  logic          exp_maj_q[$];

  // reference model: plain popcount of the whole captured word
  function automatic int model_ones(input logic [W-1:0] w);
    int n = 0;
    for (int i = 0; i < W; i++) n += int'(w[i]);
    return n;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[W-1:0];
  endfunction

  task automatic push_exp(input logic [W-1:0] w);
    int n;
    n = model_ones(w);
    exp_q.push_back(CW'(n));
    exp_maj_q.push_back(n > W / 2);
  endtask

  // driver tasks
  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("wait_idle_timeout", 64'(bus.busy), 64'd0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!bus.done && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("wait_done_timeout", 64'(bus.done), 64'd1);
  endtask

  task automatic issue(input logic [W-1:0] w);
    @(negedge clk);
    wait_idle();
    bus.start   = 1'b1;
    bus.data_in = w;
    push_exp(w);
    @(negedge clk);
    bus.start   = 1'b0;
    bus.data_in = rand_word();
  endtask

  // monitor / scoreboard
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_done <= 1'b0;
    end else begin
      if (bus.done) begin
        checks++;
        if (prev_done) begin
          errors++;
          $display("FAIL done_width: done high in consecutive cycles");
        end else if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: count=%0d with nothing expected", bus.count);
        end else begin
          logic [CW-1:0] e;
          logic          em;
          e  = exp_q.pop_front();
          em = exp_maj_q.pop_front();
          if (bus.count !== e) begin
            errors++;
            $display("FAIL result_count: got %0d expected %0d", bus.count, e);
          end
`ifdef OC_MAJORITY_EN
          checks++;
          if (bus.majority !== em) begin
            errors++;
            $display("FAIL result_majority: got %0b expected %0b (count %0d)", bus.majority, em, e);
          end
`endif
        end
      end
      prev_done <= bus.done;
    end
  end

  initial begin
    int busy_cnt;
    int done_at;
    int n;
    logic [W-1:0] a;

    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.data_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_count", 64'(bus.count), 64'd0);
    chk("reset_state", 64'(bus.state), 64'(IDLE));
`ifdef OC_MAJORITY_EN
    chk("reset_majority", 64'(bus.majority), 64'd0);
`endif
    rst_n = 1'b1;

    // Test 1: zero word, latency and busy length
    @(negedge clk);
    bus.start   = 1'b1;
    bus.data_in = '0;
    push_exp('0);
    busy_cnt = 0;
    done_at  = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) bus.start = 1'b0;
      if (bus.busy) busy_cnt++;
      if (bus.done && done_at == 0) done_at = i;
    end
    chk("t1_done_latency", 64'(done_at), 64'(NSLICE + 1));
    chk("t1_busy_cycles", 64'(busy_cnt), 64'(NSLICE + 1));

    // Test 2: directed operands
    issue(28'hFFFFFFF);
    issue(28'h000007F);
    issue(28'hAAAAAAA);
    issue(28'h0007FFF);
    wait_idle();
    chk("t2_count_holds", 64'(bus.count), 64'd15);

    // Test 3: start held high across two operations
    @(negedge clk);
    wait_idle();
    bus.start   = 1'b1;
    bus.data_in = 28'h0000001;
    push_exp(28'h0000001);
    @(negedge clk);
    bus.data_in = 28'h0000003;
    push_exp(28'h0000003);
    wait_done();
    @(negedge clk);
    chk("t3_gap_idle", 64'(bus.busy), 64'd0);
    @(negedge clk);
    chk("t3_b2b_accept", 64'(bus.busy), 64'd1);
    bus.start = 1'b0;
    wait_idle();

    // Test 4: start during RUN ignored
    a = rand_word();
    issue(a);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.data_in = ~a;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
    repeat (8) @(negedge clk);
    chk("t4_count_after_ignored", 64'(bus.count), 64'(model_ones(a)));
    chk("t4_stays_idle", 64'(bus.busy), 64'd0);

    // Test 5: reset mid-RUN
    issue(28'hFFFFFFF);
    wait_idle();
    issue(28'h5555555);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    exp_maj_q.delete();
    #1;
    chk("t5_rst_busy", 64'(bus.busy), 64'd0);
    chk("t5_rst_count", 64'(bus.count), 64'd0);
    chk("t5_rst_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("t5_no_done_after_rst", 64'(bus.busy), 64'd0);
    bus.start   = 1'b1;
    bus.data_in = 28'h000007F;
    push_exp(28'h000007F);
    @(negedge clk);
    chk("t5_first_start_accepted", 64'(bus.busy), 64'd1);
    bus.start = 1'b0;

    // random operands with occasional ignored starts
    for (int k = 0; k < 24; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(rand_word());
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
        bus.start   = 1'b1;
        bus.data_in = rand_word();
        @(negedge clk);
        bus.start = 1'b0;
      end
    end

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (8) @(negedge clk);
    chk("drain_expected_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
